regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 16x16 CPU register file: configurable width and depth, true write enable, registered dual read ports with write-through bypass, and an optional hard-wired zero register.
- Adds a sequential bulk-clear engine that zeroes the file one entry per cycle while reads continue.
- Sits between the decode stage (selects) and the ALU (A/B operands); the write-back path drives In.

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers; power of two, >= 2
ZERO_REG, 0, when 1, index 0 always reads 0 and writes to it are discarded

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
WriteEnable  input  1  write request for this cycle
SelectInput  input  AW  write index, where AW = clog2(DEPTH)
In  input  WIDTH  write data
SelectA  input  AW  read index, port A
SelectB  input  AW  read index, port B
A  output  WIDTH  registered read data, port A
B  output  WIDTH  registered read data, port B
Clear  input  1  start a bulk clear; single-cycle pulse
Busy  output  1  high while a clear is in progress
WriteDropped  output  1  one-cycle pulse when a write request was discarded

Behaviour:
Reset and interface
- Reset is sampled only at the rising edge of Clock (Reset==0). On reset: all entries, A, B, Busy, WriteDropped and the clear index go to 0; FSM goes to IDLE.

Write acceptance
- A write is accepted when all of the following hold: WriteEnable=1, state IDLE, and not (ZERO_REG=1 and SelectInput=0).
- On acceptance, mem[SelectInput] <= In at the edge.
- WriteDropped <= 1 on the next edge when WriteEnable=1 but the write was not accepted (CLEAR state, or zero-register target); otherwise it is 0.

Reads
- Read latency is 1 cycle. At each edge A <= f(SelectA) and B <= f(SelectB), where f(s) is:
  - 0 if ZERO_REG=1 and s=0;
  - else In if a write to s is accepted this cycle (write-through bypass);
  - else 0 if state is CLEAR and s equals the index being cleared this cycle;
  - else mem[s].
- A and B are fully independent. SelectA=SelectB is legal and yields A=B.

Clear FSM (states IDLE, CLEAR)
- IDLE -> CLEAR on Clear=1.
  - A write accepted in that same cycle still lands; it is overwritten later by the sweep.
  - ClrIdx <= 0; Busy <= 1.
- In CLEAR, each cycle: mem[ClrIdx] <= 0 and ClrIdx <= ClrIdx + 1.
  - When ClrIdx = DEPTH-1, that entry is cleared and the FSM returns to IDLE; Busy <= 0 at the same edge.
  - The clear therefore takes exactly DEPTH cycles with Busy=1.
- Clear=1 while in CLEAR is ignored; the sweep does not restart.
- Reset mid-clear: immediate return to IDLE with every entry zeroed.
- ClrIdx is AW bits wide; wrap-around is never reached because the exit is taken at DEPTH-1.
- Reads during CLEAR of entries not yet swept return their old contents.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (IDLE, CLEAR);
  - the function clog2;
  - a localparam default for WIDTH, 16, matching the CPU data width.
- Storage is behavioural: an array of DEPTH entries of WIDTH bits.
- One natural sub-module is regfile_clear_fsm, which owns the state, ClrIdx and Busy and outputs ClrActive/ClrIdx to the storage logic.
- Everything else stays in regfile_param.

Test Plan:
- Reset, then write 16'hBEEF to r3; next cycle SelectA=3, SelectB=3 -> A=B=16'hBEEF one cycle later.
- Bypass: in the same cycle, WriteEnable=1, SelectInput=5, In=16'h1234, SelectA=5 -> A=16'h1234 at the next edge. SelectB=6 (never written) -> B=0.
- WriteEnable=0 with SelectInput=2, In=16'hFFFF -> r2 stays 0 and WriteDropped stays 0.
- ZERO_REG=1: write 16'hAAAA to r0 -> WriteDropped=1 for one cycle; reading r0 returns 0.
- Fill r0..r15 with 16'h0100+i, then pulse Clear:
  - Busy is high for exactly 16 cycles.
  - Reading r15 at sweep cycle 2 returns 16'h010F; after Busy falls, every entry reads 0.
  - A write issued mid-sweep raises WriteDropped and is not stored.
- Assert Reset=0 for one edge at sweep cycle 5 -> Busy=0, A=B=0, all entries 0. A subsequent write to r7 (16'h0007) reads back correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps one entry per cycle from index 0 to DEPTH-1.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          clr_active_c,
    output logic [AW-1:0] clr_idx,
    output logic          busy
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Clear requests arriving mid-sweep are ignored; exit is taken at the last index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign clr_active_c = (state_q == ST_CLEAR);
    assign clr_idx      = idx_q;
    assign busy         = busy_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised dual-read register file with write-through bypass and bulk clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH    = 16,
    parameter  bit          ZERO_REG = 1'b0,
    localparam int unsigned AW       = clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WriteEnable,
    input  logic [AW-1:0]    SelectInput,
    input  logic [WIDTH-1:0] In,
    input  logic [AW-1:0]    SelectA,
    input  logic [AW-1:0]    SelectB,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic             Clear,
    output logic             Busy,
    output logic             WriteDropped
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             wd_q, wd_d;
    logic             clr_active_c;
    logic [AW-1:0]    clr_idx;
    logic             wr_acc_c;

    regfile_clear_fsm #(
        .DEPTH(DEPTH)
    ) u_clear_fsm (
        .clk         (Clock),
        .rst_n       (Reset),
        .clear       (Clear),
        .clr_active_c(clr_active_c),
        .clr_idx     (clr_idx),
        .busy        (Busy)
    );

    assign wr_acc_c = WriteEnable && !clr_active_c && !(ZERO_REG && (SelectInput == '0));

    // Next storage image: accepted write, or the entry being swept.
    always_comb begin
        mem_d = mem_q;
        wd_d  = WriteEnable && !wr_acc_c;
        if (wr_acc_c) begin
            mem_d[SelectInput] = In;
        end
        if (clr_active_c) begin
            mem_d[clr_idx] = '0;
        end
    end

    // Read priority: zero register, bypass, in-flight clear, stored value.
    always_comb begin
        a_d = mem_q[SelectA];
        b_d = mem_q[SelectB];
        if (ZERO_REG && (SelectA == '0)) begin
            a_d = '0;
        end else if (wr_acc_c && (SelectA == SelectInput)) begin
            a_d = In;
        end else if (clr_active_c && (SelectA == clr_idx)) begin
            a_d = '0;
        end
        if (ZERO_REG && (SelectB == '0)) begin
            b_d = '0;
        end else if (wr_acc_c && (SelectB == SelectInput)) begin
            b_d = In;
        end else if (clr_active_c && (SelectB == clr_idx)) begin
            b_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            a_q  <= '0;
            b_q  <= '0;
            wd_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            a_q   <= a_d;
            b_q   <= b_d;
            wd_q  <= wd_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign WriteDropped = wd_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: plain register file and zero-register variant driven in lockstep.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n, we, clear;
    logic [3:0]  sel_in, sel_a, sel_b;
    logic [15:0] din;
    logic [15:0] a0, b0, a1, b1;
    logic        busy0, busy1, wd0, wd1;

    logic [15:0] obs_a [2];
    logic [15:0] obs_b [2];
    logic        obs_busy [2];
    logic        obs_wd [2];

    assign obs_a[0] = a0;    assign obs_a[1] = a1;
    assign obs_b[0] = b0;    assign obs_b[1] = b1;
    assign obs_busy[0] = busy0; assign obs_busy[1] = busy1;
    assign obs_wd[0] = wd0;  assign obs_wd[1] = wd1;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0)) u_dut0 (
        .Clock(clk), .Reset(rst_n), .WriteEnable(we), .SelectInput(sel_in), .In(din),
        .SelectA(sel_a), .SelectB(sel_b), .A(a0), .B(b0), .Clear(clear),
        .Busy(busy0), .WriteDropped(wd0)
    );

    regfile_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .WriteEnable(we), .SelectInput(sel_in), .In(din),
        .SelectA(sel_a), .SelectB(sel_b), .A(a1), .B(b1), .Clear(clear),
        .Busy(busy1), .WriteDropped(wd1)
    );

    // Reference model: contents per instance, sweep progress as a cycle count.
    logic [15:0] mdl [2][16];
    bit          m_busy;
    int          m_swept;
    logic [15:0] exp_a [2];
    logic [15:0] exp_b [2];
    bit          exp_wd [2];
    bit          exp_busy;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] model_read(int k, logic [3:0] s, bit acc);
        if (k == 1 && s == 4'd0) return 16'h0;
        if (acc && s == sel_in) return din;
        if (m_busy && int'(s) == m_swept) return 16'h0;
        return mdl[k][s];
    endfunction

    task automatic tick();
        bit acc;
        for (int k = 0; k < 2; k++) begin
            acc       = we && !m_busy && !(k == 1 && sel_in == 4'd0);
            exp_a[k]  = model_read(k, sel_a, acc);
            exp_b[k]  = model_read(k, sel_b, acc);
            exp_wd[k] = we && !acc;
            if (acc) mdl[k][sel_in] = din;
            if (m_busy) mdl[k][m_swept] = 16'h0;
        end
        if (m_busy) begin
            m_swept = m_swept + 1;
            if (m_swept == 16) m_busy = 1'b0;
        end else if (clear) begin
            m_busy  = 1'b1;
            m_swept = 0;
        end
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 16; i++) mdl[k][i] = 16'h0;
                exp_a[k]  = 16'h0;
                exp_b[k]  = 16'h0;
                exp_wd[k] = 1'b0;
            end
            m_busy  = 1'b0;
            m_swept = 0;
        end
        exp_busy = m_busy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; we = 1'b0; clear = 1'b0;
        sel_in = 4'd0; sel_a = 4'd0; sel_b = 4'd0; din = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; we = 1'b1; clear = 1'b1; sel_in = 4'd4; din = 16'hDEAD;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a[k] !== 16'h0 || obs_b[k] !== 16'h0 || obs_busy[k] !== 1'b0 || obs_wd[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: A=%h B=%h Busy=%b WD=%b, required all 0",
                         k, obs_a[k], obs_b[k], obs_busy[k], obs_wd[k]);
            end
        end
        idle_inputs();
        for (int s = 0; s < 16; s++) begin
            sel_a = 4'(s); sel_b = 4'(15 - s);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_a[k] !== 16'h0 || obs_b[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset_contents inst%0d r%0d: A=%h B=%h, required 0", k, s, obs_a[k], obs_b[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        we = 1'b1; sel_in = 4'd3; din = 16'hBEEF;
        tick();
        we = 1'b0; sel_a = 4'd3; sel_b = 4'd3;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a[k] !== 16'hBEEF || obs_b[k] !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL write_read inst%0d: A=%h B=%h, required BEEF", k, obs_a[k], obs_b[k]);
            end
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1'b1; sel_in = 4'd5; din = 16'h1234; sel_a = 4'd5; sel_b = 4'd6;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a[k] !== 16'h1234 || obs_b[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL bypass inst%0d: A=%h B=%h, required A=1234 B=0000", k, obs_a[k], obs_b[k]);
            end
        end
    endtask

    task automatic test_no_write();
        idle_inputs();
        we = 1'b0; sel_in = 4'd2; din = 16'hFFFF; sel_a = 4'd2;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a[k] !== 16'h0 || obs_wd[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL no_write inst%0d: r2=%h WD=%b, required r2=0000 WD=0", k, obs_a[k], obs_wd[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        we = 1'b1; sel_in = 4'd0; din = 16'hAAAA; sel_a = 4'd0; sel_b = 4'd0;
        tick();
        n_checks++;
        if (wd1 !== 1'b1 || a1 !== 16'h0 || wd0 !== 1'b0 || a0 !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL zero_reg_write: zr WD=%b A=%h (req 1,0000) plain WD=%b A=%h (req 0,AAAA)", wd1, a1, wd0, a0);
        end
        we = 1'b0;
        tick();
        n_checks++;
        if (wd1 !== 1'b0 || a1 !== 16'h0 || b1 !== 16'h0 || a0 !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL zero_reg_read: zr WD=%b A=%h B=%h (req 0,0000,0000) plain A=%h (req AAAA)", wd1, a1, b1, a0);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; sel_in = 4'(i); din = 16'h0100 + 16'(i);
            tick();
        end
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cnt = (busy0 === 1'b1) ? 1 : 0;
        n_checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_start: Busy=%b/%b, required 1", busy0, busy1);
        end
        for (int j = 0; j < 20; j++) begin
            sel_a = (j == 2) ? 4'd15 : 4'(j);
            sel_b = 4'($urandom_range(15));
            we = (j == 4); sel_in = 4'd9; din = 16'h5555;
            clear = (j == 7);
            tick();
            if (busy0 === 1'b1) busy_cnt++;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_a[k] !== exp_a[k] || obs_b[k] !== exp_b[k] || obs_wd[k] !== exp_wd[k] || obs_busy[k] !== exp_busy) begin
                    n_fail++;
                    $display("FAIL sweep inst%0d cyc%0d: A=%h B=%h WD=%b Busy=%b, required %h %h %b %b",
                             k, j, obs_a[k], obs_b[k], obs_wd[k], obs_busy[k], exp_a[k], exp_b[k], exp_wd[k], exp_busy);
                end
            end
            if (j == 2) begin
                n_checks++;
                if (a0 !== 16'h010F || a1 !== 16'h010F) begin
                    n_fail++;
                    $display("FAIL sweep_unswept_r15: A=%h/%h, required 010F", a0, a1);
                end
            end
            if (j == 4) begin
                n_checks++;
                if (wd0 !== 1'b1 || wd1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_write_dropped: WD=%b/%b, required 1", wd0, wd1);
                end
            end
        end
        n_checks++;
        if (busy_cnt != 16) begin
            n_fail++;
            $display("FAIL clear_busy_cycles: %0d, required 16", busy_cnt);
        end
        idle_inputs();
        for (int s = 0; s < 16; s++) begin
            sel_a = 4'(s); sel_b = 4'(s);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_a[k] !== 16'h0 || obs_b[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL after_clear inst%0d r%0d: A=%h B=%h, required 0", k, s, obs_a[k], obs_b[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; sel_in = 4'(i); din = 16'($urandom_range(16'hFFFF, 1));
            tick();
        end
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        rst_n = 1'b0; sel_a = 4'd12; sel_b = 4'd13;
        tick();
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0 || b1 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: Busy=%b/%b A=%h/%h B=%h/%h, required all 0", busy0, busy1, a0, a1, b0, b1);
        end
        idle_inputs();
        for (int s = 0; s < 16; s++) begin
            sel_a = 4'(s); sel_b = 4'(15 - s);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_a[k] !== 16'h0 || obs_b[k] !== 16'h0 || obs_busy[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_contents inst%0d r%0d: A=%h B=%h Busy=%b, required 0", k, s, obs_a[k], obs_b[k], obs_busy[k]);
                end
            end
        end
        we = 1'b1; sel_in = 4'd7; din = 16'h0007;
        tick();
        we = 1'b0; sel_a = 4'd7; sel_b = 4'd7;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a[k] !== 16'h0007 || obs_b[k] !== 16'h0007) begin
                n_fail++;
                $display("FAIL post_reset_write inst%0d: A=%h B=%h, required 0007", k, obs_a[k], obs_b[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n  = ($urandom_range(99) != 0);
            we     = $urandom_range(1) == 1;
            clear  = ($urandom_range(24) == 0);
            sel_in = 4'($urandom_range(15));
            sel_a  = ($urandom_range(3) == 0) ? sel_in : 4'($urandom_range(15));
            sel_b  = ($urandom_range(3) == 0) ? sel_a : 4'($urandom_range(15));
            din    = 16'($urandom_range(16'hFFFF));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_a[k] !== exp_a[k] || obs_b[k] !== exp_b[k] || obs_wd[k] !== exp_wd[k] || obs_busy[k] !== exp_busy) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: A=%h B=%h WD=%b Busy=%b, required %h %h %b %b",
                             k, c, obs_a[k], obs_b[k], obs_wd[k], obs_busy[k], exp_a[k], exp_b[k], exp_wd[k], exp_busy);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mdl[k][i] = 16'h0;
        end
        m_busy = 1'b0;
        m_swept = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_no_write();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
